// File: rtl/ring_mem_ctrl.sv
// Ring-tail memory controller: snoops ADDR/WDATA slots into FIFOs, serves whole cache-line
// reads/writes on an on-chip RAM and streams read beats onto the pipelined mc_* bus.
module ring_mem_ctrl #(
  parameter int TSIZE   = 4,
  parameter int SSIZE   = 4,
  parameter int NBWORDS = 3,
  parameter int MBITS   = 14,
  parameter int QLOG    = 4,
  parameter int RD_LAT  = 1,
  parameter int T_ADDR  = 2,
  parameter int T_WDATA = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TSIZE-1:0]   slot_type,
  input  logic [SSIZE-1:0]   slot_source,
  input  logic [31:0]        slot_data,
  output logic               mc_valid,
  output logic [SSIZE-1:0]   mc_dest,
  output logic [NBWORDS-1:0] mc_count,
  output logic [31:0]        mc_data,
  output logic               mc_err,
  output logic               busy,
  output logic               ovf
);
  localparam int NWORDS = 1 << NBWORDS;
  localparam int LW     = 30 - NBWORDS;      // line field width; bit LW of slot_data is the write flag
  localparam int AW     = SSIZE + 1 + LW;
  localparam int WLOG   = QLOG + NBWORDS;
  localparam int LBITS  = MBITS - NBWORDS;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t             state_q, state_d;
  logic [NBWORDS-1:0] bcnt_q, bcnt_d;
  logic               ovf_q;

  logic [AW-1:0]   aq_mem [1 << QLOG];
  logic [QLOG-1:0] aq_rd_q, aq_wr_q, aq_nxt_idx;
  logic [QLOG:0]   aq_cnt_q;
  logic            aq_push_req, aq_full, aq_push, aq_pop;

  logic [31:0]     wq_mem [1 << WLOG];
  logic [WLOG-1:0] wq_rd_q, wq_wr_q;
  logic [WLOG:0]   wq_cnt_q, wq_left;
  logic            wq_push_req, wq_full, wq_push, wq_pop;

  logic [31:0]     ram [1 << MBITS];
  logic [MBITS-1:0] ram_addr;
  logic            ram_we, rd_issue;

  logic [SSIZE-1:0] h_src;
  logic             h_wr, h_oor, n_wr, head_ok, next_ok, pipe_any;
  logic [LW-1:0]    h_line;

  logic               p_vld_q [RD_LAT];
  logic [SSIZE-1:0]   p_dst_q [RD_LAT];
  logic [NBWORDS-1:0] p_cnt_q [RD_LAT];
  logic               p_err_q [RD_LAT];
  logic [31:0]        dat_q   [RD_LAT];

  assign aq_push_req = (slot_type == TSIZE'(T_ADDR));
  assign wq_push_req = (slot_type == TSIZE'(T_WDATA));
  assign aq_full     = (aq_cnt_q == (QLOG+1)'(1 << QLOG));
  assign wq_full     = (wq_cnt_q == (WLOG+1)'(1 << WLOG));
  assign aq_push     = aq_push_req && (!aq_full || aq_pop);
  assign wq_push     = wq_push_req && (!wq_full || wq_pop);

  assign {h_src, h_wr, h_line} = aq_mem[aq_rd_q];
  assign h_oor      = |h_line[LW-1:LBITS];
  assign aq_nxt_idx = aq_rd_q + QLOG'(1);
  assign n_wr       = aq_mem[aq_nxt_idx][LW];
  assign ram_addr   = {h_line[LBITS-1:0], bcnt_q};

  // A write is only started once its whole line of data sits in WQ.
  assign head_ok = (aq_cnt_q != '0) && (!h_wr || wq_cnt_q >= (WLOG+1)'(NWORDS));
  assign wq_left = wq_cnt_q - (WLOG+1)'(h_wr);
  assign next_ok = (aq_cnt_q > (QLOG+1)'(1)) && (!n_wr || wq_left >= (WLOG+1)'(NWORDS));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    aq_pop   = 1'b0;
    wq_pop   = 1'b0;
    ram_we   = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (head_ok) begin
          state_d = S_XFER;
          bcnt_d  = '0;
        end
      end
      S_XFER: begin
        wq_pop   = h_wr;
        ram_we   = h_wr && !h_oor;
        rd_issue = !h_wr;
        bcnt_d   = bcnt_q + NBWORDS'(1);
        if (bcnt_q == '1) begin
          aq_pop = 1'b1;
          if (!next_ok) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      aq_rd_q  <= '0;
      aq_wr_q  <= '0;
      aq_cnt_q <= '0;
      wq_rd_q  <= '0;
      wq_wr_q  <= '0;
      wq_cnt_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        p_vld_q[i] <= 1'b0;
        p_dst_q[i] <= '0;
        p_cnt_q[i] <= '0;
        p_err_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      if (aq_push) aq_wr_q <= aq_wr_q + QLOG'(1);
      if (aq_pop)  aq_rd_q <= aq_nxt_idx;
      aq_cnt_q <= aq_cnt_q + (QLOG+1)'(aq_push) - (QLOG+1)'(aq_pop);
      if (wq_push) wq_wr_q <= wq_wr_q + WLOG'(1);
      if (wq_pop)  wq_rd_q <= wq_rd_q + WLOG'(1);
      wq_cnt_q <= wq_cnt_q + (WLOG+1)'(wq_push) - (WLOG+1)'(wq_pop);
      if ((aq_push_req && !aq_push) || (wq_push_req && !wq_push)) ovf_q <= 1'b1;
      p_vld_q[0] <= rd_issue;
      p_dst_q[0] <= rd_issue ? h_src : '0;
      p_cnt_q[0] <= rd_issue ? bcnt_q : '0;
      p_err_q[0] <= rd_issue && h_oor;
      for (int i = 1; i < RD_LAT; i++) begin
        p_vld_q[i] <= p_vld_q[i-1];
        p_dst_q[i] <= p_dst_q[i-1];
        p_cnt_q[i] <= p_cnt_q[i-1];
        p_err_q[i] <= p_err_q[i-1];
      end
    end
  end

  // NOTE: queue storage, RAM and the data delay line are not reset; pointers and valids hide stale contents.
  always_ff @(posedge clk) begin
    if (aq_push) aq_mem[aq_wr_q] <= {slot_source, slot_data[LW], slot_data[LW-1:0]};
    if (wq_push) wq_mem[wq_wr_q] <= slot_data;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= wq_mem[wq_rd_q];
    dat_q[0] <= ram[ram_addr];
    for (int i = 1; i < RD_LAT; i++) dat_q[i] <= dat_q[i-1];
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_any = pipe_any | p_vld_q[i];
  end

  assign mc_valid = p_vld_q[RD_LAT-1];
  assign mc_dest  = p_dst_q[RD_LAT-1];
  assign mc_count = p_cnt_q[RD_LAT-1];
  assign mc_err   = p_err_q[RD_LAT-1];
  assign mc_data  = (mc_valid && !mc_err) ? dat_q[RD_LAT-1] : 32'd0;
  assign busy     = (aq_cnt_q != '0) || (state_q == S_XFER) || pipe_any;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_ring_mem_ctrl.sv
// Bench for ring_mem_ctrl: directed scenarios plus random slot traffic, all checked every
// cycle against a queue-based transaction model of the controller.
module tb_ring_mem_ctrl;
  localparam int NBW = 3;
  localparam int NW  = 1 << NBW;
  localparam int MB  = 6;
  localparam int QL  = 2;
  localparam int RL  = 3;
  localparam int LPM = 1 << (MB - NBW);
  localparam int AQD = 1 << QL;
  localparam int WQD = 1 << (QL + NBW);

  logic        clk, reset;
  logic [3:0]  slot_type, slot_source;
  logic [31:0] slot_data;
  logic        mc_valid, mc_err, busy, ovf;
  logic [3:0]  mc_dest;
  logic [2:0]  mc_count;
  logic [31:0] mc_data;

  int errors = 0;
  int checks = 0;

  ring_mem_ctrl #(
    .TSIZE(4), .SSIZE(4), .NBWORDS(NBW), .MBITS(MB), .QLOG(QL), .RD_LAT(RL),
    .T_ADDR(2), .T_WDATA(3)
  ) dut (
    .clk(clk), .reset(reset), .slot_type(slot_type), .slot_source(slot_source),
    .slot_data(slot_data), .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_count(mc_count),
    .mc_data(mc_data), .mc_err(mc_err), .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct { logic [3:0] src; logic wr; logic [26:0] line; } areq_t;
  typedef struct { int due; logic [3:0] dest; logic [2:0] cnt; logic err; logic [31:0] data; } beat_t;

  areq_t       aq_m[$];
  logic [31:0] wq_m[$];
  beat_t       exp_q[$];
  logic [31:0] mem_m [LPM*NW];
  int          beats_left = 0;
  int          cyc = 0;
  bit          ovf_m = 0;

  areq_t       e_m;
  beat_t       b_m;
  int          k_m, idx_m;
  bit          oor_m;
  logic [31:0] w_m;

  function automatic bit eligible(input areq_t e, input int wavail);
    return !e.wr || wavail >= NW;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aq_m.delete(); wq_m.delete(); exp_q.delete();
      beats_left = 0;
      ovf_m = 0;
    end else begin
      cyc++;
      if (beats_left == 0) begin
        if (aq_m.size() > 0 && eligible(aq_m[0], wq_m.size())) beats_left = NW;
      end else begin
        e_m   = aq_m[0];
        k_m   = NW - beats_left;
        oor_m = (e_m.line >= 27'(LPM));
        idx_m = int'(e_m.line % 27'(LPM)) * NW + k_m;
        if (e_m.wr) begin
          w_m = wq_m.pop_front();
          if (!oor_m) mem_m[idx_m] = w_m;
        end else begin
          b_m.due  = cyc + RL - 1;
          b_m.dest = e_m.src;
          b_m.cnt  = k_m[2:0];
          b_m.err  = oor_m;
          b_m.data = oor_m ? 32'd0 : mem_m[idx_m];
          exp_q.push_back(b_m);
        end
        beats_left--;
        if (beats_left == 0) begin
          void'(aq_m.pop_front());
          if (aq_m.size() > 0 && eligible(aq_m[0], wq_m.size())) beats_left = NW;
        end
      end
      if (slot_type == 4'd2) begin
        if (aq_m.size() < AQD) begin
          e_m.src = slot_source; e_m.wr = slot_data[27]; e_m.line = slot_data[26:0];
          aq_m.push_back(e_m);
        end else ovf_m = 1;
      end else if (slot_type == 4'd3) begin
        if (wq_m.size() < WQD) wq_m.push_back(slot_data);
        else ovf_m = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  beat_t cb;
  bit    exp_busy;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("reset mc_valid", 32'(mc_valid), 32'd0);
      check("reset mc_data", mc_data, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);
    end else begin
      exp_busy = (aq_m.size() > 0) || (beats_left > 0) || (exp_q.size() > 0);
      check("busy", 32'(busy), 32'(exp_busy));
      check("ovf", 32'(ovf), 32'(ovf_m));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        cb = exp_q.pop_front();
        check("beat valid", 32'(mc_valid), 32'd1);
        check("beat dest", 32'(mc_dest), 32'(cb.dest));
        check("beat count", 32'(mc_count), 32'(cb.cnt));
        check("beat err", 32'(mc_err), 32'(cb.err));
        check("beat data", mc_data, cb.data);
      end else begin
        check("idle valid", 32'(mc_valid), 32'd0);
        check("idle dest", 32'(mc_dest), 32'd0);
        check("idle data", mc_data, 32'd0);
        check("idle err", 32'(mc_err), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    slot_type = t; slot_source = s; slot_data = d;
  endtask

  task automatic put_idle();
    put(4'd0, 4'd0, 32'd0);
  endtask

  task automatic put_addr(input logic [3:0] s, input logic wr, input logic [26:0] line);
    put(4'd2, s, {4'b0, wr, line});
  endtask

  task automatic put_wdata(input logic [31:0] d);
    put(4'd3, 4'd0, d);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    put_idle();
    while (busy !== 1'b0 && n < 2000) begin
      edges(1);
      n++;
    end
    if (n >= 2000) check("wait_idle timeout busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] init_word(input int l, input int w);
    return (l == 1) ? 32'h10 + 32'(w) : 32'hC000_0000 + 32'(l * 256 + w);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int nv;
  int r, l;
  logic [3:0]  ot;
  logic [26:0] rl;

  initial begin
    reset = 1'b1;
    slot_type = '0; slot_source = '0; slot_data = '0;
    repeat (2) @(negedge clk);
    check("post-reset mc_valid", 32'(mc_valid), 32'd0);
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset ovf", 32'(ovf), 32'd0);
    reset = 1'b0;

    // Fill every in-range line so all later reads have defined data.
    for (int ln = 0; ln < LPM; ln++) begin
      put_addr(4'd7, 1'b1, 27'(ln));
      for (int w = 0; w < NW; w++) put_wdata(init_word(ln, w));
      wait_idle();
    end
    check("init no ovf", 32'(ovf), 32'd0);

    // Read line 1 from source 2: beats at N+1+RL .. N+RL+NW.
    put_addr(4'd2, 1'b0, 27'd1);
    put_idle();
    edges(RL);
    check("rd1 before beat0 valid", 32'(mc_valid), 32'd0);
    edges(1);
    check("rd1 beat0 valid", 32'(mc_valid), 32'd1);
    check("rd1 beat0 data", mc_data, 32'h10);
    check("rd1 beat0 dest", 32'(mc_dest), 32'd2);
    check("rd1 beat0 count", 32'(mc_count), 32'd0);
    edges(NW - 1);
    check("rd1 beat7 data", mc_data, 32'h17);
    check("rd1 beat7 count", 32'(mc_count), 32'd7);
    edges(1);
    check("rd1 after last valid", 32'(mc_valid), 32'd0);
    wait_idle();

    // Write line 3 with slowly arriving data; the read behind it must wait.
    put_addr(4'd1, 1'b1, 27'd3);
    put_addr(4'd5, 1'b0, 27'd3);
    for (int i = 0; i < 7; i++) begin
      put_wdata(32'hA0 + 32'(i));
      put_idle();
    end
    edges(1);
    check("wr3 waiting busy", 32'(busy), 32'd1);
    check("wr3 waiting no beat", 32'(mc_valid), 32'd0);
    put_wdata(32'hA7);
    put_idle();
    edges(8 + RL);
    check("raw before beat0 valid", 32'(mc_valid), 32'd0);
    edges(1);
    check("raw beat0 valid", 32'(mc_valid), 32'd1);
    check("raw beat0 data", mc_data, 32'hA0);
    check("raw beat0 dest", 32'(mc_dest), 32'd5);
    edges(NW - 1);
    check("raw beat7 data", mc_data, 32'hA7);
    wait_idle();

    // Two reads one cycle apart give 16 contiguous beats.
    put_addr(4'd1, 1'b0, 27'd0);
    put_addr(4'd3, 1'b0, 27'd2);
    put_idle();
    edges(RL - 1);
    check("pair before valid", 32'(mc_valid), 32'd0);
    for (int i = 0; i < 2 * NW; i++) begin
      edges(1);
      check("pair beat valid", 32'(mc_valid), 32'd1);
      check("pair beat dest", 32'(mc_dest), (i < NW) ? 32'd1 : 32'd3);
    end
    edges(1);
    check("pair after valid", 32'(mc_valid), 32'd0);
    wait_idle();

    // Out-of-range read and write.
    put_addr(4'd4, 1'b0, 27'(LPM));
    put_idle();
    edges(1 + RL);
    check("oor beat0 valid", 32'(mc_valid), 32'd1);
    check("oor beat0 err", 32'(mc_err), 32'd1);
    check("oor beat0 data", mc_data, 32'd0);
    wait_idle();
    put_addr(4'd4, 1'b1, 27'(LPM));
    for (int w = 0; w < NW; w++) put_wdata(32'hEE00 + 32'(w));
    wait_idle();
    put_addr(4'd6, 1'b0, 27'd0);
    put_idle();
    edges(1 + RL);
    check("alias line0 data", mc_data, init_word(0, 0));
    check("alias line0 err", 32'(mc_err), 32'd0);
    wait_idle();

    // Overflow: a waiting write plus three reads fill AQ; the fifth ADDR is dropped.
    put_addr(4'd1, 1'b1, 27'd4);
    put_addr(4'd2, 1'b0, 27'd4);
    put_addr(4'd3, 1'b0, 27'd5);
    put_addr(4'd4, 1'b0, 27'd6);
    edges(1);
    check("ovf clear at full", 32'(ovf), 32'd0);
    put_addr(4'd5, 1'b0, 27'd7);
    put_idle();
    check("ovf set on drop", 32'(ovf), 32'd1);
    for (int w = 0; w < NW; w++) put_wdata(32'hB0 + 32'(w));
    wait_idle();
    check("ovf sticky", 32'(ovf), 32'd1);
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk); reset = 1'b0;
    check("ovf cleared by reset", 32'(ovf), 32'd0);

    // Reset in the middle of a read.
    put_addr(4'd2, 1'b0, 27'd1);
    put_idle();
    edges(1 + RL + 4);
    check("mid beat4 count", 32'(mc_count), 32'd4);
    check("mid beat4 valid", 32'(mc_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async rst mc_valid", 32'(mc_valid), 32'd0);
    check("async rst mc_data", mc_data, 32'd0);
    check("async rst mc_dest", 32'(mc_dest), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk); reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      if (mc_valid) nv++;
    end
    check("no beats after reset", 32'(nv), 32'd0);
    put_addr(4'd2, 1'b0, 27'd1);
    put_idle();
    edges(1 + RL);
    check("post-rst read data", mc_data, 32'h10);
    check("post-rst read dest", 32'(mc_dest), 32'd2);
    wait_idle();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 18) begin
        l  = $urandom_range(0, LPM + 1);
        rl = (l > LPM) ? (27'($urandom) | 27'(LPM)) : 27'(l);
        put_addr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rl);
      end else if (r < 55) begin
        put_wdata($urandom);
      end else begin
        ot = 4'($urandom_range(0, 15));
        if (ot == 4'd2 || ot == 4'd3) ot = 4'd9;
        put(ot, 4'($urandom_range(0, 15)), $urandom);
      end
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
      end
    end

    // Feed data until every queued write has completed, then drain.
    for (int i = 0; i < 400 && aq_m.size() > 0; i++) put_wdata($urandom);
    wait_idle();
    check("final aq empty", 32'(aq_m.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
